// File: rtl/frv_mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and response owner.
package frv_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/frv_mem_arbiter.sv
// Shares one req/gnt memory port between instruction fetch and load/store.
// Data side wins ties; fetch is guaranteed a grant after DMEM_BURST_MAX data grants.
module frv_mem_arbiter
  import frv_mem_arb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int DMEM_BURST_MAX = 4
) (
  input  logic            g_clk,
  input  logic            g_resetn,

  input  logic            imem_req,
  input  logic            imem_wen,
  input  logic [3:0]      imem_strb,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_error,
  output logic [XLEN-1:0] imem_rdata,

  input  logic            dmem_req,
  input  logic            dmem_wen,
  input  logic [3:0]      dmem_strb,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_addr,
  output logic            dmem_gnt,
  output logic            dmem_error,
  output logic [XLEN-1:0] dmem_rdata,

  output logic            mem_req,
  output logic            mem_wen,
  output logic [3:0]      mem_strb,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_error,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(DMEM_BURST_MAX);

  arb_state_t r_state;
  arb_owner_t r_rsp_owner;
  logic [3:0] r_burst_cnt;

  arb_owner_t w_sel;
  logic       w_sel_i;

  // A held request keeps its selection; only IDLE re-arbitrates.
  always_comb begin
    w_sel = D;
    case (r_state)
      HOLD_I:  w_sel = I;
      HOLD_D:  w_sel = D;
      default: begin
        if (imem_req && (!dmem_req || (r_burst_cnt == BURST_MAX)))
          w_sel = I;
        else
          w_sel = D;
      end
    endcase
  end

  assign w_sel_i = (w_sel == I);

  assign mem_req   = w_sel_i ? imem_req   : dmem_req;
  assign mem_wen   = w_sel_i ? imem_wen   : dmem_wen;
  assign mem_strb  = w_sel_i ? imem_strb  : dmem_strb;
  assign mem_wdata = w_sel_i ? imem_wdata : dmem_wdata;
  assign mem_addr  = w_sel_i ? imem_addr  : dmem_addr;

  assign imem_gnt = mem_gnt &&  w_sel_i && imem_req;
  assign dmem_gnt = mem_gnt && !w_sel_i && dmem_req;

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_error = mem_error && (r_rsp_owner == I);
  assign dmem_error = mem_error && (r_rsp_owner == D);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state     <= IDLE;
      r_rsp_owner <= NONE;
      r_burst_cnt <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req && !mem_gnt)
            r_state <= w_sel_i ? HOLD_I : HOLD_D;
        end
        // A dropped request is a protocol violation; abandon the hold.
        HOLD_I: if (!imem_req || mem_gnt) r_state <= IDLE;
        HOLD_D: if (!dmem_req || mem_gnt) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (imem_gnt)
        r_rsp_owner <= I;
      else if (dmem_gnt)
        r_rsp_owner <= D;
      else
        r_rsp_owner <= NONE;

      if (!imem_req || imem_gnt)
        r_burst_cnt <= 4'd0;
      else if (dmem_gnt && (r_burst_cnt != BURST_MAX))
        r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter with a per-cycle reference model of the
// lock / starvation / response-owner rules plus hand-computed expectations.
module tb_frv_mem_arbiter;

  localparam int XLEN = 32;
  localparam int BMAX = 4;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            imem_req = 1'b0, imem_wen = 1'b0;
  logic [3:0]      imem_strb = 4'h0;
  logic [XLEN-1:0] imem_wdata = '0, imem_addr = '0;
  logic            imem_gnt, imem_error;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req = 1'b0, dmem_wen = 1'b0;
  logic [3:0]      dmem_strb = 4'h0;
  logic [XLEN-1:0] dmem_wdata = '0, dmem_addr = '0;
  logic            dmem_gnt, dmem_error;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_req, mem_wen;
  logic [3:0]      mem_strb;
  logic [XLEN-1:0] mem_wdata, mem_addr;
  logic            mem_gnt = 1'b0, mem_error = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  always #5 g_clk = ~g_clk;

  frv_mem_arbiter #(.XLEN(XLEN), .DMEM_BURST_MAX(BMAX)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_error(imem_error), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr),
    .dmem_gnt(dmem_gnt), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: lock = side whose request is waiting on the bus (0 none, 1 fetch, 2 data),
  // starve = data grants handed out while fetch kept waiting, owner = side due a response.
  int m_lock = 0, m_starve = 0, m_owner = 0;
  int nx_lock = 0, nx_starve = 0, nx_owner = 0;

  always @(negedge g_clk) begin : cmp
    int  side;
    logic sreq, gi, gd;
    side = m_lock;
    if (side == 0) begin
      if (imem_req && dmem_req) side = (m_starve >= BMAX) ? 1 : 2;
      else if (imem_req)        side = 1;
      else if (dmem_req)        side = 2;
    end
    sreq = (side == 1) ? imem_req : (side == 2) ? dmem_req : 1'b0;
    gi   = mem_gnt && (side == 1) && imem_req;
    gd   = mem_gnt && (side == 2) && dmem_req;

    chk("m_mem_req", {31'd0, mem_req}, {31'd0, sreq});
    chk("m_imem_gnt", {31'd0, imem_gnt}, {31'd0, gi});
    chk("m_dmem_gnt", {31'd0, dmem_gnt}, {31'd0, gd});
    if (side == 1) begin
      chk("m_addr", mem_addr, imem_addr);
      chk("m_wdata", mem_wdata, imem_wdata);
      chk("m_strb", {28'd0, mem_strb}, {28'd0, imem_strb});
      chk("m_wen", {31'd0, mem_wen}, {31'd0, imem_wen});
    end else begin
      chk("m_addr", mem_addr, dmem_addr);
      chk("m_wdata", mem_wdata, dmem_wdata);
      chk("m_strb", {28'd0, mem_strb}, {28'd0, dmem_strb});
      chk("m_wen", {31'd0, mem_wen}, {31'd0, dmem_wen});
    end
    chk("m_imem_rdata", imem_rdata, mem_rdata);
    chk("m_dmem_rdata", dmem_rdata, mem_rdata);
    chk("m_imem_error", {31'd0, imem_error}, {31'd0, mem_error && (m_owner == 1)});
    chk("m_dmem_error", {31'd0, dmem_error}, {31'd0, mem_error && (m_owner == 2)});

    nx_lock  = (sreq && !mem_gnt) ? side : 0;
    nx_owner = gi ? 1 : (gd ? 2 : 0);
    if (!imem_req || gi)        nx_starve = 0;
    else if (gd)                nx_starve = (m_starve + 1 > BMAX) ? BMAX : m_starve + 1;
    else                        nx_starve = m_starve;
  end

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      m_lock   <= 0;
      m_starve <= 0;
      m_owner  <= 0;
    end else begin
      m_lock   <= nx_lock;
      m_starve <= nx_starve;
      m_owner  <= nx_owner;
    end
  end

  // Applies one cycle of inputs at posedge+1; returns at posedge+2 for direct checks.
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic g, input logic e);
    @(posedge g_clk);
    #1;
    imem_req   = ir;  imem_addr = ia;  imem_wdata = ia ^ 32'hA5A5_0000;
    imem_strb  = 4'hF; imem_wen = 1'b0;
    dmem_req   = dr;  dmem_addr = da;  dmem_wdata = da ^ 32'h0000_5A5A;
    dmem_strb  = 4'h3; dmem_wen = 1'b1;
    mem_gnt    = g;   mem_error = e;   mem_rdata = $urandom;
    #1;
  endtask

  string pat;

  initial begin
    mem_gnt = 1'b1;
    mem_error = 1'b1;
    #3;
    chk("rst_imem_gnt", {31'd0, imem_gnt}, 32'd0);
    chk("rst_dmem_gnt", {31'd0, dmem_gnt}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_imem_error", {31'd0, imem_error}, 32'd0);
    chk("rst_dmem_error", {31'd0, dmem_error}, 32'd0);
    repeat (2) @(posedge g_clk);
    #2 g_resetn = 1'b1;

    drive(0, 32'h0, 0, 32'h0, 0, 0);

    // Fetch-only stream, response errors routed to fetch
    drive(1, 32'h8000_0000, 0, 32'h0, 1, 0);
    chk("t1_gnt0", {31'd0, imem_gnt}, 32'd1);
    chk("t1_addr0", mem_addr, 32'h8000_0000);
    drive(1, 32'h8000_0004, 0, 32'h0, 1, 1);
    chk("t1_gnt1", {31'd0, imem_gnt}, 32'd1);
    chk("t1_addr1", mem_addr, 32'h8000_0004);
    chk("t1_ierr1", {31'd0, imem_error}, 32'd1);
    chk("t1_derr1", {31'd0, dmem_error}, 32'd0);
    drive(1, 32'h8000_0008, 0, 32'h0, 1, 0);
    chk("t1_gnt2", {31'd0, imem_gnt}, 32'd1);
    chk("t1_addr2", mem_addr, 32'h8000_0008);
    chk("t1_ierr2", {31'd0, imem_error}, 32'd0);
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    chk("t1_ierr3", {31'd0, imem_error}, 32'd1);
    chk("t1_derr3", {31'd0, dmem_error}, 32'd0);

    // Both request, bus stalls three cycles: data side held
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h8000_0100, 1, 32'h1000_0000, (k == 3), 0);
      chk("t2_addr", mem_addr, 32'h1000_0000);
      chk("t2_dgnt", {31'd0, dmem_gnt}, (k == 3) ? 32'd1 : 32'd0);
      chk("t2_ignt", {31'd0, imem_gnt}, 32'd0);
    end
    drive(0, 32'h0, 0, 32'h0, 0, 0);

    // Continuous contention: starvation bound lets fetch in every 5th grant
    pat = "";
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h8000_0200, 1, 32'h1000_0100 + 32'(4 * k), 1, 0);
      pat = {pat, imem_gnt ? "I" : (dmem_gnt ? "D" : "-")};
    end
    n_tests++;
    if (pat != "DDDDIDDDDI") begin
      n_fail++;
      $display("[TB] FAIL t3_pattern: got %s expected DDDDIDDDDI", pat);
    end
    drive(0, 32'h0, 0, 32'h0, 0, 0);

    // Data response error coinciding with a fetch grant
    drive(0, 32'h0, 1, 32'h1000_0200, 1, 0);
    chk("t4_dgnt", {31'd0, dmem_gnt}, 32'd1);
    drive(1, 32'h8000_0300, 0, 32'h0, 1, 1);
    chk("t4_derr", {31'd0, dmem_error}, 32'd1);
    chk("t4_ierr", {31'd0, imem_error}, 32'd0);
    chk("t4_ignt", {31'd0, imem_gnt}, 32'd1);
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    chk("t4_ierr2", {31'd0, imem_error}, 32'd1);
    chk("t4_derr2", {31'd0, dmem_error}, 32'd0);

    // Fetch abandons a held request
    drive(1, 32'h8000_0400, 0, 32'h0, 0, 0);
    drive(0, 32'h8000_0400, 1, 32'h1000_0300, 1, 0);
    chk("t6_mreq", {31'd0, mem_req}, 32'd0);
    chk("t6_dgnt", {31'd0, dmem_gnt}, 32'd0);
    drive(0, 32'h8000_0400, 1, 32'h1000_0300, 1, 0);
    chk("t6_dgnt2", {31'd0, dmem_gnt}, 32'd1);
    chk("t6_mreq2", {31'd0, mem_req}, 32'd1);

    // Asynchronous reset while holding for fetch
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    drive(1, 32'h8000_0500, 0, 32'h0, 0, 0);
    drive(1, 32'h8000_0500, 1, 32'h1000_0400, 0, 0);
    chk("t5_held_addr", mem_addr, 32'h8000_0500);
    g_resetn = 1'b0;
    #1;
    chk("t5_rst_addr", mem_addr, 32'h1000_0400);
    chk("t5_rst_ignt", {31'd0, imem_gnt}, 32'd0);
    #1 g_resetn = 1'b1;
    drive(1, 32'h8000_0500, 1, 32'h1000_0400, 1, 0);
    chk("t5_post_dgnt", {31'd0, dmem_gnt}, 32'd1);
    drive(0, 32'h0, 0, 32'h0, 0, 0);

    // Reset drops an in-flight response error
    drive(1, 32'h8000_0600, 0, 32'h0, 1, 0);
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    chk("t5_err_pre", {31'd0, imem_error}, 32'd1);
    g_resetn = 1'b0;
    #1;
    chk("t5_err_rst", {31'd0, imem_error}, 32'd0);
    #1 g_resetn = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0, 1);
    chk("t5_err_post", {31'd0, imem_error}, 32'd0);

    drive(0, 32'h0, 0, 32'h0, 0, 0);
    drive(0, 32'h0, 0, 32'h0, 0, 0);
    @(posedge g_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
